// File: rtl/fan_sleep_timer.sv
// Fan sleep (off-delay) timer: button steps OFF -> preset0..N-1 -> OFF, each step restarts a BCD countdown.
// Optional build macro FAN_TIMER_SECONDS_DISPLAY_EN shows MM:SS on the display during the final hour.
module fan_sleep_timer #(
    parameter int                         NUM_PRESETS  = 3,
    parameter logic [8*NUM_PRESETS-1:0]   PRESET_HOURS = 24'h05_03_01,
    parameter int                         CLK_PER_SEC  = 100_000_000,
    parameter int                         SEC_PER_MIN  = 60
) (
    input  logic                   clk,
    input  logic                   reset_p,
    input  logic                   btn,
    input  logic                   cancel,
    output logic [NUM_PRESETS:0]   mode,
    output logic [15:0]            value,
    output logic                   running,
    output logic                   timeout,
    output logic                   fan_stop
);

    localparam int              MW        = NUM_PRESETS + 1;
    localparam int              PW        = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_PER_SEC - 1);
    localparam logic [2:0]      LAST_SEL  = 3'(NUM_PRESETS - 1);
    localparam logic [7:0]      SS_RELOAD = {4'((SEC_PER_MIN - 1) / 10), 4'((SEC_PER_MIN - 1) % 10)};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [2:0]      sel, sel_n;
    logic [7:0]      hh, hh_n, mm, mm_n, ss, ss_n;
    logic [PW-1:0]   presc, presc_n;
    logic            sec_tick, expire;

    logic [MW-1:0]   mode_n;
    logic [15:0]     value_n;
    logic            running_n, timeout_n, fan_stop_n;

    // Two-digit BCD decrement; callers never pass 00, so the tens digit cannot underflow.
    function automatic logic [7:0] bcd_dec(input logic [7:0] d);
        logic [7:0] r;
        if (d[3:0] == 4'd0)
            r = {d[7:4] - 4'd1, 4'd9};
        else
            r = {d[7:4], d[3:0] - 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] preset_hours(input logic [2:0] i);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < NUM_PRESETS; k++) begin
            if (3'(k) == i)
                r = PRESET_HOURS[8*k +: 8];
        end
        return r;
    endfunction

    assign sec_tick = (state == RUN) && (presc == PRESC_MAX);
    // The tick that would land on 00:00:00 goes straight to EXPIRED, so the pulse lands exactly H hours after the load.
    assign expire   = sec_tick && (hh == 8'h00) && (mm == 8'h00) && (ss == 8'h01);

    always_ff @(posedge clk) begin
        if (reset_p)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        hh_n      = hh;
        mm_n      = mm;
        ss_n      = ss;
        presc_n   = '0;
        timeout_n = 1'b0;

        if (cancel || (btn && state == RUN && sel == LAST_SEL)) begin
            state_n = IDLE;
            sel_n   = 3'd0;
            hh_n    = 8'h00;
            mm_n    = 8'h00;
            ss_n    = 8'h00;
        end else if (btn) begin
            state_n = RUN;
            sel_n   = (state == RUN) ? sel + 3'd1 : 3'd0;
            hh_n    = preset_hours(sel_n);
            mm_n    = 8'h00;
            ss_n    = 8'h00;
        end else if (state == RUN) begin
            if (!sec_tick) begin
                presc_n = presc + 1'b1;
            end else if (expire) begin
                state_n   = EXPIRED;
                timeout_n = 1'b1;
                sel_n     = 3'd0;
                hh_n      = 8'h00;
                mm_n      = 8'h00;
                ss_n      = 8'h00;
            end else if (ss != 8'h00) begin
                ss_n = bcd_dec(ss);
            end else begin
                ss_n = SS_RELOAD;
                if (mm != 8'h00) begin
                    mm_n = bcd_dec(mm);
                end else begin
                    hh_n = bcd_dec(hh);
                    mm_n = 8'h59;
                end
            end
        end

        running_n  = (state_n == RUN);
        fan_stop_n = (state_n == EXPIRED);
        mode_n     = running_n ? (MW'(2) << sel_n) : MW'(1);
        value_n    = 16'h0000;
        if (running_n) begin
`ifdef FAN_TIMER_SECONDS_DISPLAY_EN
            value_n = (hh_n == 8'h00) ? {mm_n, ss_n} : {hh_n, mm_n};
`else
            value_n = {hh_n, mm_n};
`endif
        end
    end

    // Counters and outputs are registered from the same next-state decode so they never disagree.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            sel      <= 3'd0;
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
            presc    <= '0;
            mode     <= MW'(1);
            value    <= 16'h0000;
            running  <= 1'b0;
            timeout  <= 1'b0;
            fan_stop <= 1'b0;
        end else begin
            sel      <= sel_n;
            hh       <= hh_n;
            mm       <= mm_n;
            ss       <= ss_n;
            presc    <= presc_n;
            mode     <= mode_n;
            value    <= value_n;
            running  <= running_n;
            timeout  <= timeout_n;
            fan_stop <= fan_stop_n;
        end
    end

endmodule
